// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - Game Boy OAM DMA sequencer (FF46 -> 160-byte copy into OAM)
//
// A write to FF46 latches the source page and copies BYTES bytes from
// {page, 00..BYTES-1} into OAM, one read (READ_WAIT granted cycles) plus one
// OAM write per byte. Echo-RAM pages E0..FF are folded down to C0..DF.
//
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_mem_enable, i_rd_n,    MMU register bus (select, read/write strobes,
//   i_wr_n, i_a, i_di, o_do  address, write data, read data)
//   o_dma_req, i_dma_gnt     source-bus request / grant
//   o_dma_addr, o_dma_rd_n,  source address, read strobe, read data
//   i_dma_di
//   o_oam_we, o_oam_addr,    OAM write port (one pulse per byte)
//   o_oam_do
//   o_dma_active             copy in progress (CPU limited to HRAM)
//   o_dma_done               one-cycle pulse after the last OAM write

module oam_dma_controller #(
  parameter int BYTES     = 160,
  parameter int READ_WAIT = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_mem_enable,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_di,
  output logic [7:0]  o_do,
  output logic        o_dma_req,
  input  logic        i_dma_gnt,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_rd_n,
  input  logic [7:0]  i_dma_di,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_do,
  output logic        o_dma_active,
  output logic        o_dma_done
);

  localparam int              WW        = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [7:0]      LAST_IDX  = 8'(BYTES - 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(READ_WAIT - 1);
  localparam logic [15:0]     REG_ADDR  = 16'hFF46;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic          r_wr_hit_d;
  logic [7:0]    r_src_hi;
  logic [7:0]    r_idx;
  logic [WW-1:0] r_wait_cnt;
  logic [7:0]    r_byte_buf;
  logic          r_done;

  logic          w_wr_hit;
  logic          w_rd_hit;
  logic          w_start;
  logic          w_last;
  logic [7:0]    w_page_hi;

  assign w_wr_hit = i_mem_enable & ~i_wr_n & (i_a == REG_ADDR);
  assign w_rd_hit = i_mem_enable & ~i_rd_n & (i_a == REG_ADDR);
  // Edge detect so a strobe held for many cycles launches only one copy.
  assign w_start  = w_wr_hit & ~r_wr_hit_d;
  assign w_last   = (r_idx == LAST_IDX);
  // Echo RAM E000..FFFF mirrors C000..DFFF.
  assign w_page_hi = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;

  assign o_do       = w_rd_hit ? r_src_hi : 8'h00;
  assign o_dma_done = r_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_dma_req    = 1'b0;
    o_dma_active = 1'b0;
    o_dma_addr   = 16'h0000;
    o_dma_rd_n   = 1'b1;
    o_oam_we     = 1'b0;
    o_oam_addr   = 8'h00;
    o_oam_do     = 8'h00;
    case (r_state)
      S_READ: begin
        o_dma_req    = 1'b1;
        o_dma_active = 1'b1;
        o_dma_addr   = {w_page_hi, r_idx};
        o_dma_rd_n   = ~i_dma_gnt;
        if (i_dma_gnt && (r_wait_cnt == WAIT_LAST)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_dma_req    = 1'b1;
        o_dma_active = 1'b1;
        o_oam_we     = 1'b1;
        o_oam_addr   = r_idx;
        o_oam_do     = r_byte_buf;
        w_state_next = w_last ? S_IDLE : S_READ;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A new FF46 write restarts from byte 0 whatever is in flight.
    if (w_start) begin
      w_state_next = S_READ;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_hit_d <= 1'b0;
      r_src_hi   <= 8'hFF;
      r_idx      <= 8'h00;
      r_wait_cnt <= '0;
      r_byte_buf <= 8'h00;
      r_done     <= 1'b0;
    end else begin
      r_wr_hit_d <= w_wr_hit;
      // A restart landing on the final write cancels the completion pulse.
      r_done     <= (r_state == S_WRITE) && w_last && !w_start;
      if (w_start) begin
        r_src_hi   <= i_di;
        r_idx      <= 8'h00;
        r_wait_cnt <= '0;
      end else begin
        case (r_state)
          S_READ: begin
            if (!i_dma_gnt) begin
              // Losing the bus discards partial wait progress.
              r_wait_cnt <= '0;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_byte_buf <= i_dma_di;
              r_wait_cnt <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_WRITE: begin
            if (!w_last) begin
              r_idx <= r_idx + 8'h01;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - directed self-checking bench for oam_dma_controller

module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] a;
  logic [7:0]  di;
  logic [7:0]  rdata;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_addr;
  logic        dma_rd_n;
  logic [7:0]  dma_di;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_do;
  logic        dma_active;
  logic        dma_done;

  always #15 clock = ~clock;

  oam_dma_controller #(.BYTES(160), .READ_WAIT(1)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_mem_enable (mem_enable),
    .i_rd_n       (rd_n),
    .i_wr_n       (wr_n),
    .i_a          (a),
    .i_di         (di),
    .o_do         (rdata),
    .o_dma_req    (dma_req),
    .i_dma_gnt    (dma_gnt),
    .o_dma_addr   (dma_addr),
    .o_dma_rd_n   (dma_rd_n),
    .i_dma_di     (dma_di),
    .o_oam_we     (oam_we),
    .o_oam_addr   (oam_addr),
    .o_oam_do     (oam_do),
    .o_dma_active (dma_active),
    .o_dma_done   (dma_done)
  );

  // Source memory contents: a fixed scramble of the address.
  function automatic logic [7:0] src_fn(input logic [15:0] ad);
    return ad[7:0] ^ {ad[14:8], ad[15]} ^ 8'hA5;
  endfunction

  assign dma_di = src_fn(dma_addr);

  int n_cmp  = 0;
  int n_fail = 0;

  // Negedge monitor: running totals, the bench compares differences.
  int          cyc_total = 0, we_total = 0, done_total = 0, rd_total = 0;
  int          last_we_cyc = 0, last_done_cyc = 0;
  int          seq_err = 0, data_err = 0, addr_err = 0, gnt_err = 0;
  logic [15:0] last_rd_addr = 16'h0;
  logic [7:0]  exp_next = 8'h00;
  logic [7:0]  exp_hi = 8'h00;
  logic [7:0]  oam_mem [0:159];

  always @(negedge clock) begin
    cyc_total++;
    if (dma_rd_n === 1'b0) begin
      rd_total++;
      last_rd_addr = dma_addr;
      if (dma_gnt !== 1'b1) gnt_err++;
      if (dma_addr[15:8] !== exp_hi ||
          (dma_addr[7:0] !== exp_next && dma_addr[7:0] !== 8'h00)) addr_err++;
    end
    if (oam_we === 1'b1) begin
      we_total++;
      last_we_cyc = cyc_total;
      if (dma_gnt !== 1'b1) gnt_err++;
      if (oam_addr !== exp_next && oam_addr !== 8'h00) seq_err++;
      if (oam_do !== src_fn({exp_hi, oam_addr})) data_err++;
      if (oam_addr < 8'd160) oam_mem[oam_addr] = oam_do;
      exp_next = oam_addr + 8'h01;
    end
    if (dma_done === 1'b1) begin
      done_total++;
      last_done_cyc = cyc_total;
    end
  end

  int b_cyc, b_we, b_done, b_rd, b_seq, b_data, b_addr, b_gnt;
  int b_we0, b_done0, bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_cyc  = cyc_total;
    b_we   = we_total;
    b_done = done_total;
    b_rd   = rd_total;
    b_seq  = seq_err;
    b_data = data_err;
    b_addr = addr_err;
    b_gnt  = gnt_err;
  endtask

  // Start edge is the second posedge; stats are snapshotted there.
  task automatic cpu_write(input logic [7:0] v, input int hold);
    @(posedge clock);
    #1;
    mem_enable = 1'b1;
    wr_n       = 1'b0;
    a          = 16'hFF46;
    di         = v;
    @(posedge clock);
    snap();
    repeat (hold - 1) @(posedge clock);
    #1;
    mem_enable = 1'b0;
    wr_n       = 1'b1;
    a          = 16'h0000;
  endtask

  task automatic reg_read(input string tag, input logic [7:0] exp);
    mem_enable = 1'b1;
    rd_n       = 1'b0;
    a          = 16'hFF46;
    #2;
    check(tag, {24'h0, rdata}, {24'h0, exp});
    mem_enable = 1'b0;
    rd_n       = 1'b1;
    a          = 16'h0000;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_total == b_done; i++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req"},    {31'h0, dma_req},    32'h0);
    check({p, "_active"}, {31'h0, dma_active}, 32'h0);
    check({p, "_addr"},   {16'h0, dma_addr},   32'h0);
    check({p, "_rd_n"},   {31'h0, dma_rd_n},   32'h1);
    check({p, "_we"},     {31'h0, oam_we},     32'h0);
    check({p, "_oaddr"},  {24'h0, oam_addr},   32'h0);
    check({p, "_odata"},  {24'h0, oam_do},     32'h0);
    check({p, "_done"},   {31'h0, dma_done},   32'h0);
    check({p, "_do"},     {24'h0, rdata},      32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    dma_gnt    = 1'b1;
    mem_enable = 1'b0;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    a          = 16'h0000;
    di         = 8'h00;
    for (int i = 0; i < 160; i++) oam_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reg_read("rst_reg", 8'hFF);
    reset = 1'b0;

    // Basic transfer from page C1
    exp_hi = 8'hC1;
    cpu_write(8'hC1, 1);
    check("t1_active0", {31'h0, dma_active}, 32'h1);
    check("t1_req0",    {31'h0, dma_req},    32'h1);
    check("t1_addr0",   {16'h0, dma_addr},   32'hC100);
    check("t1_rdn0",    {31'h0, dma_rd_n},   32'h0);
    check("t1_we0",     {31'h0, oam_we},     32'h0);
    wait_done(400);
    check("t1_we_cnt",   we_total - b_we,         160);
    check("t1_rd_cnt",   rd_total - b_rd,         160);
    check("t1_seq",      seq_err - b_seq,         0);
    check("t1_data",     data_err - b_data,       0);
    check("t1_addr",     addr_err - b_addr,       0);
    check("t1_last_rd",  {16'h0, last_rd_addr},   32'hC19F);
    check("t1_last_we",  last_we_cyc - b_cyc,     320);
    check("t1_done_cyc", last_done_cyc - b_cyc,   321);
    check("t1_done_cnt", done_total - b_done,     1);
    check("t1_idle",     {31'h0, dma_active},     32'h0);
    reg_read("t1_reg", 8'hC1);

    // Strobe held for 10 cycles: one transfer only
    exp_hi = 8'hC2;
    cpu_write(8'hC2, 10);
    wait_done(400);
    repeat (20) @(posedge clock);
    #1;
    check("t2_we_cnt",   we_total - b_we,       160);
    check("t2_done_cnt", done_total - b_done,   1);
    check("t2_done_cyc", last_done_cyc - b_cyc, 321);

    // Echo page E3 maps to C3
    exp_hi = 8'hC3;
    cpu_write(8'hE3, 1);
    check("t3_addr0", {16'h0, dma_addr}, 32'hC300);
    wait_done(400);
    check("t3_last_rd", {16'h0, last_rd_addr}, 32'hC39F);
    check("t3_addr",    addr_err - b_addr,     0);
    check("t3_data",    data_err - b_data,     0);
    check("t3_we_cnt",  we_total - b_we,       160);
    reg_read("t3_reg", 8'hE3);

    // Grant dropped for 5 cycles at the read of byte 40
    exp_hi = 8'hC4;
    cpu_write(8'hC4, 1);
    repeat (80) @(posedge clock);
    #1;
    dma_gnt = 1'b0;
    @(posedge clock);
    #1;
    check("t4_rdn_low", {31'h0, dma_rd_n}, 32'h1);
    check("t4_req_low", {31'h0, dma_req},  32'h1);
    check("t4_we_low",  {31'h0, oam_we},   32'h0);
    check("t4_addr",    {16'h0, dma_addr}, 32'hC428);
    repeat (4) @(posedge clock);
    #1;
    dma_gnt = 1'b1;
    wait_done(400);
    check("t4_gnt_err",  gnt_err - b_gnt,       0);
    check("t4_we_cnt",   we_total - b_we,       160);
    check("t4_last_we",  last_we_cyc - b_cyc,   325);
    check("t4_done_cyc", last_done_cyc - b_cyc, 326);
    check("t4_data",     data_err - b_data,     0);
    check("t4_addr_err", addr_err - b_addr,     0);

    // Restart with page 90 during byte 70 of a page-80 copy
    exp_hi = 8'h80;
    cpu_write(8'h80, 1);
    b_done0 = b_done;
    repeat (140) @(posedge clock);
    exp_hi = 8'h90;
    cpu_write(8'h90, 1);
    wait_done(400);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam_mem[i] !== src_fn({8'h90, 8'(i)})) bad++;
    check("t5_oam_img",  bad,                    0);
    check("t5_done_cnt", done_total - b_done0,   1);
    check("t5_done_cyc", last_done_cyc - b_cyc,  321);

    // Restart landing on the final OAM write
    exp_hi = 8'hD0;
    cpu_write(8'hD0, 1);
    b_we0   = b_we;
    b_done0 = b_done;
    repeat (318) @(posedge clock);
    exp_hi = 8'hD1;
    cpu_write(8'hD1, 1);
    check("t6_addr0",  {16'h0, dma_addr},   32'hD100);
    check("t6_active", {31'h0, dma_active}, 32'h1);
    check("t6_we0",    {31'h0, oam_we},     32'h0);
    wait_done(400);
    check("t6_we_cnt",   we_total - b_we0,      320);
    check("t6_done_cnt", done_total - b_done0,  1);
    check("t6_done_cyc", last_done_cyc - b_cyc, 321);

    // Reset at byte 100 aborts the copy
    exp_hi = 8'hC5;
    cpu_write(8'hC5, 1);
    repeat (200) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("t7");
    reg_read("t7_reg", 8'hFF);
    reset = 1'b0;
    repeat (400) @(posedge clock);
    #1;
    check("t7_done_cnt", done_total - b_done, 0);
    check("t7_we_cnt",   we_total - b_we,     100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequences Game Boy OAM DMA: a CPU write to register FF46 starts a 160-byte copy from a source page (source high byte, low byte 00..9F) into sprite attribute memory (OAM, FE00..FE9F) inside the video block. It sits between the MMU's video-register bus and the video module's OAM write port. It requests the shared source bus from the MMU arbiter and flags the CPU-blocking window while the copy runs.

## Interface
Parameters:
- `BYTES`, 160: bytes per transfer; OAM index runs 0..BYTES-1.
- `READ_WAIT`, 1: granted cycles `dma_rd_n` is held low per byte before `dma_di` is sampled (≥1).

Ports:
- `clock` input 1: 33 MHz system clock; single clock domain.
- `reset` input 1: synchronous, active-high.
- `mem_enable` input 1: MMU select for this register space.
- `rd_n` input 1: MMU read strobe, active low.
- `wr_n` input 1: MMU write strobe, active low.
- `A` input 16: MMU address.
- `di` input 8: MMU write data.
- `do` output 8: register read data.
- `dma_req` output 1: source-bus request to the MMU arbiter.
- `dma_gnt` input 1: source-bus grant.
- `dma_addr` output 16: source address.
- `dma_rd_n` output 1: source read strobe, active low.
- `dma_di` input 8: source read data.
- `oam_we` output 1: OAM write enable, one-cycle pulse per byte.
- `oam_addr` output 8: OAM byte index.
- `oam_do` output 8: OAM write data.
- `dma_active` output 1: transfer in progress; the CPU is restricted to HRAM.
- `dma_done` output 1: one-cycle pulse after the last OAM write.

## Operation
- Register hit: `wr_hit = mem_enable & ~wr_n & (A == 16'hFF46)`. A start is the rising edge of `wr_hit` (registered `wr_hit_d`). A strobe held for many cycles starts exactly one transfer.
- On a start: `src_hi <= di`, `idx <= 0`, `wait_cnt <= 0`, `byte_buf` unchanged, state goes to READ. This applies from any state, so a write during an active transfer restarts at byte 0 with the new page.
- `page_hi` = `src_hi - 8'h20` if `src_hi >= 8'hE0` (echo RAM maps to C0..DF), otherwise `src_hi`.
- `do` is combinational: `src_hi` when `mem_enable & ~rd_n & (A == 16'hFF46)`, otherwise `8'h00`.
- States:
  - IDLE: `dma_req=0`, `dma_rd_n=1`, `dma_active=0`.
  - READ: `dma_req=1`, `dma_active=1`, `dma_addr={page_hi, idx}`, `dma_rd_n = ~dma_gnt`.
    - If `dma_gnt` is high, `wait_cnt` increments. When `wait_cnt == READ_WAIT-1` with the grant high: `byte_buf <= dma_di`, `wait_cnt <= 0`, go to WRITE.
    - If `dma_gnt` is low, `wait_cnt <= 0` and the state stays READ, so the byte is retried from scratch.
  - WRITE: `dma_req=1`, `dma_active=1`, `dma_rd_n=1`, `oam_we=1`, `oam_addr=idx`, `oam_do=byte_buf`. The OAM write does not need the grant.
    - If `idx == BYTES-1`: go to IDLE and pulse `dma_done` on the next cycle.
    - Otherwise: `idx <= idx+1`, go to READ.
- `idx` never exceeds BYTES-1 and never wraps.
- Start and WRITE on the same edge: the start wins. The pending OAM write still issues that cycle, and the next state is READ with `idx=0`.
- Reset values:
  - `src_hi=8'hFF`; `idx`, `wait_cnt`, `byte_buf` = 0; state IDLE.
  - Outputs: `do=0` (absent a read hit), `dma_req=0`, `dma_addr=0`, `dma_rd_n=1`, `oam_we=0`, `oam_addr=0`, `oam_do=0`, `dma_active=0`, `dma_done=0`.
  - Reset mid-transfer aborts immediately; no further OAM writes and no `dma_done`.

## Timing
- State-derived outputs (`dma_req`, `dma_active`, `oam_*`, `dma_addr`) are registered or decoded from the state register. `dma_rd_n` depends combinationally on `dma_gnt`.
- Start latency: `wr_hit` rises before edge N; `dma_active` and `dma_req` are high from edge N.
- With the grant held high, each byte takes READ_WAIT+1 cycles. With READ_WAIT=1 the full transfer is 320 cycles: the last `oam_we` occurs in cycle 320 after the start, `dma_active` falls at edge 320, and `dma_done` is high for cycle 321.
- The arbiter may drop `dma_gnt` at any edge. Each granted-low READ cycle adds one cycle, plus repeated wait cycles for READ_WAIT>1.

## Test plan
- Write `8'hC1` to FF46 with grant tied high and READ_WAIT=1 → `dma_addr` C100..C19F in order; 160 `oam_we` pulses carrying `oam_addr` 0..159 and the matching source data; `dma_done` at cycle 321; `do` reads `8'hC1`.
- Hold `wr_n` low for 10 cycles on FF46 → exactly one transfer (160 OAM writes).
- Write `8'hE3` → source addresses C300..C39F.
- Drop `dma_gnt` for 5 cycles at byte 40 → `dma_rd_n` stays high, no `oam_we` while the grant is low, byte 40 is read after the grant returns, and the total is 325 cycles.
- Write `8'h80` at byte 70, then `8'h90` → OAM bytes 0..159 hold page 90 data and a single `dma_done`.
- Assert `reset` at byte 100 → all outputs at reset values next cycle, `do` reads `8'hFF`, no `dma_done`.
